// File: rtl/out_uart_tx.sv
// Output-port UART transmitter: CPU writes bytes into a small FIFO, an FSM serialises them 8N1 (LSB first).
// Optional even-parity bit (8E1 framing) when macro OUT_UART_TX_PARITY_EN is defined.
module out_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_wrOut,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_full,
  output logic       o_overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [7:0]    BAUD_LAST  = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef OUT_UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

`ifdef OUT_UART_TX_PARITY_EN
  function automatic logic evenParity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic          overflowR;

  // Serialiser state
  state_t        state;
  state_t        stateNext;
  logic [7:0]    shiftReg;
  logic [7:0]    shiftNext;
  logic [2:0]    bitCnt;
  logic [2:0]    bitCntNext;
  logic [7:0]    baudCnt;
  logic [7:0]    baudNext;
  logic          txReg;
  logic          txNext;
`ifdef OUT_UART_TX_PARITY_EN
  logic          parityReg;
`endif

  logic fifoEmpty;
  logic fifoFull;
  logic pop;
  logic push;
  logic drop;

  // Pop decision uses only pre-edge registered state, so a write into an
  // empty FIFO can never be popped on the same edge.
  assign fifoEmpty = (count == {CW{1'b0}});
  assign fifoFull  = (count == FULL_COUNT);
  assign pop       = (state == IDLE) && !fifoEmpty;
  assign push      = i_wrOut && (!fifoFull || pop);
  assign drop      = i_wrOut && fifoFull && !pop;

  // FIFO pointer, occupancy and sticky overflow registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wrPtr     <= {PW{1'b0}};
      rdPtr     <= {PW{1'b0}};
      count     <= {CW{1'b0}};
      overflowR <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflowR <= 1'b1;
      end
    end
  end

  // FIFO data array; contents are don't-care while the pointers say empty
  always_ff @(posedge i_clk) begin
    if (!i_reset && push) begin
      fifoMem[wrPtr] <= i_data;
    end
  end

  // Next-state and next-line-level logic; o_tx is the registered txNext
  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    bitCntNext = bitCnt;
    baudNext   = baudCnt;
    txNext     = txReg;
    case (state)
      IDLE: begin
        if (pop) begin
          stateNext  = START;
          shiftNext  = fifoMem[rdPtr];
          bitCntNext = 3'd0;
          baudNext   = 8'd0;
          txNext     = 1'b0;
        end else begin
          stateNext  = IDLE;
          txNext     = 1'b1;
        end
      end
      START: begin
        if (baudCnt == BAUD_LAST) begin
          stateNext = DATA;
          baudNext  = 8'd0;
          txNext    = shiftReg[0];
        end else begin
          baudNext  = baudCnt + 8'd1;
          txNext    = 1'b0;
        end
      end
      DATA: begin
        if (baudCnt == BAUD_LAST) begin
          baudNext = 8'd0;
          if (bitCnt == 3'd7) begin
`ifdef OUT_UART_TX_PARITY_EN
            stateNext = PARITY;
            txNext    = parityReg;
`else
            stateNext = STOP;
            txNext    = 1'b1;
`endif
          end else begin
            bitCntNext = bitCnt + 3'd1;
            shiftNext  = {1'b0, shiftReg[7:1]};
            txNext     = shiftReg[1];
          end
        end else begin
          baudNext = baudCnt + 8'd1;
          txNext   = shiftReg[0];
        end
      end
`ifdef OUT_UART_TX_PARITY_EN
      PARITY: begin
        if (baudCnt == BAUD_LAST) begin
          stateNext = STOP;
          baudNext  = 8'd0;
          txNext    = 1'b1;
        end else begin
          baudNext  = baudCnt + 8'd1;
          txNext    = parityReg;
        end
      end
`endif
      STOP: begin
        if (baudCnt == BAUD_LAST) begin
          stateNext = IDLE;
          baudNext  = 8'd0;
        end else begin
          baudNext  = baudCnt + 8'd1;
        end
        txNext = 1'b1;
      end
      default: begin
        stateNext = IDLE;
        baudNext  = 8'd0;
        txNext    = 1'b1;
      end
    endcase
  end

  // Serialiser state register; reset aborts any frame in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      shiftReg <= 8'd0;
      bitCnt   <= 3'd0;
      baudCnt  <= 8'd0;
      txReg    <= 1'b1;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      bitCnt   <= bitCntNext;
      baudCnt  <= baudNext;
      txReg    <= txNext;
    end
  end

`ifdef OUT_UART_TX_PARITY_EN
  // Parity is captured from the whole byte at pop time, before it is shifted out
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      parityReg <= 1'b0;
    end else if (pop) begin
      parityReg <= evenParity(fifoMem[rdPtr]);
    end
  end
`endif

  assign o_tx       = txReg;
  assign o_busy     = (state != IDLE) || !fifoEmpty;
  assign o_full     = fifoFull;
  assign o_overflow = overflowR;

endmodule

// File: tb/tb_out_uart_tx.sv
// Scoreboard bench for out_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4, parity disabled).
module tb_out_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_data;
  logic       i_wrOut;
  logic       o_tx;
  logic       o_busy;
  logic       o_full;
  logic       o_overflow;

  int checks = 0;
  int errors = 0;
  int frames = 0;

  typedef struct {
    logic [7:0] data;
    int         gap;
    bit         abort;
  } exp_t;

  exp_t sbQ[$];

  always #5 clk = ~clk;

  out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_data    (i_data),
    .i_wrOut   (i_wrOut),
    .o_tx      (o_tx),
    .o_busy    (o_busy),
    .o_full    (o_full),
    .o_overflow(o_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input int g, input bit a);
    exp_t e;
    e.data  = d;
    e.gap   = g;
    e.abort = a;
    return e;
  endfunction

  task automatic writeOne(input logic [7:0] d);
    @(negedge clk);
    i_data  = d;
    i_wrOut = 1'b1;
    @(posedge clk);
  endtask

  task automatic endWrite();
    @(negedge clk);
    i_wrOut = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (o_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: decodes every frame on o_tx cycle by cycle and compares with the scoreboard
  initial begin : monitor
    int         idleRun;
    logic [7:0] d;
    bit         ok;
    exp_t       e;
    logic       v;
    idleRun = 0;
    forever begin
      @(negedge clk);
      if (o_tx === 1'b0) begin
        ok = 1'b1;
        d  = 8'h00;
        for (int i = 1; i < CPB; i++) begin
          @(negedge clk);
          if (o_tx !== 1'b0) ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
          for (int j = 0; j < CPB; j++) begin
            @(negedge clk);
            v = o_tx;
            if (j == 0) d[b] = v;
            else if (v !== d[b]) ok = 1'b0;
          end
        end
        frames++;
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=%0h required=none", d);
        end else begin
          e = sbQ.pop_front();
          if (!e.abort) begin
            check("frame_data", {23'd0, ok, d}, {23'd0, 1'b1, e.data});
            if (e.gap >= 0) check("frame_gap", idleRun, e.gap);
            else check("frame_gap_min", 32'(idleRun >= CPB), 32'd1);
          end
        end
        idleRun = 0;
      end else if (o_tx === 1'b1) begin
        idleRun++;
      end else begin
        idleRun = 0;
      end
    end
  end

  initial begin : stimulus
    i_reset = 1'b1;
    i_wrOut = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", o_tx, 1);
    check("rst_busy", o_busy, 0);
    check("rst_full", o_full, 0);
    check("rst_ovf", o_overflow, 0);
    i_reset = 1'b0;
    repeat (10) @(negedge clk);

    // Single frame 0xA5: exact latency and busy window
    sbQ.push_back(mk(8'hA5, -1, 1'b0));
    writeOne(8'hA5);
    endWrite();
    check("lat_tx_c0", o_tx, 1);
    check("lat_busy_c0", o_busy, 1);
    @(negedge clk);
    check("lat_tx_c1", o_tx, 0);
    repeat (39) @(negedge clk);
    check("stop_tx_c40", o_tx, 1);
    check("busy_c40", o_busy, 1);
    @(negedge clk);
    check("busy_c41", o_busy, 0);
    waitIdle();

    // Back-to-back 0x00 then 0xFF: stop+idle gap is CPB+1
    sbQ.push_back(mk(8'h00, -1, 1'b0));
    sbQ.push_back(mk(8'hFF, CPB + 1, 1'b0));
    writeOne(8'h00);
    writeOne(8'hFF);
    endWrite();
    waitIdle();

    // Five consecutive writes while idle: all accepted, FIFO ends full
    sbQ.push_back(mk(8'h11, -1, 1'b0));
    sbQ.push_back(mk(8'h22, CPB + 1, 1'b0));
    sbQ.push_back(mk(8'h33, CPB + 1, 1'b0));
    sbQ.push_back(mk(8'h44, CPB + 1, 1'b0));
    sbQ.push_back(mk(8'h55, CPB + 1, 1'b0));
    writeOne(8'h11);
    writeOne(8'h22);
    writeOne(8'h33);
    writeOne(8'h44);
    writeOne(8'h55);
    endWrite();
    check("five_full", o_full, 1);
    check("five_ovf", o_overflow, 0);
    waitIdle();
    check("five_empty_full", o_full, 0);

    // Fill during a frame, then write 0x3C while full: dropped
    sbQ.push_back(mk(8'hA1, -1, 1'b0));
    writeOne(8'hA1);
    endWrite();
    repeat (5) @(negedge clk);
    sbQ.push_back(mk(8'hB2, CPB + 1, 1'b0));
    sbQ.push_back(mk(8'hC3, CPB + 1, 1'b0));
    sbQ.push_back(mk(8'hD4, CPB + 1, 1'b0));
    sbQ.push_back(mk(8'hE5, CPB + 1, 1'b0));
    writeOne(8'hB2);
    writeOne(8'hC3);
    writeOne(8'hD4);
    writeOne(8'hE5);
    endWrite();
    check("fill_full", o_full, 1);
    check("fill_ovf_before", o_overflow, 0);
    writeOne(8'h3C);
    endWrite();
    check("fill_ovf_after", o_overflow, 1);
    waitIdle();
    check("ovf_sticky", o_overflow, 1);

    // Reset during DATA bit 3, with a write offered during reset
    sbQ.push_back(mk(8'h5A, -1, 1'b1));
    writeOne(8'h5A);
    endWrite();
    repeat (18) @(negedge clk);
    check("pre_rst_busy", o_busy, 1);
    i_reset = 1'b1;
    i_wrOut = 1'b1;
    i_data  = 8'h77;
    @(negedge clk);
    check("mid_rst_tx", o_tx, 1);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_ovf", o_overflow, 0);
    check("mid_rst_full", o_full, 0);
    i_reset = 1'b0;
    i_wrOut = 1'b0;
    @(negedge clk);
    check("post_rst_busy", o_busy, 0);
    repeat (100) @(negedge clk);

    check("sb_empty", sbQ.size(), 0);
    check("frame_count", frames, 14);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
